// File: rtl/dcm_monitor.sv
// Recovers the 3-bit program code of a generated slow clock by measuring its
// high/low half-periods in system cycles. Optional stall timeout: DCM_MONITOR_TIMEOUT_EN.
module dcm_monitor #(
  parameter int HUNDREDMHZ = 10,
  parameter int TIMEOUT    = 256
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clock_in,
  input  logic       update,
  input  logic [2:0] expect_in,
  output logic [2:0] code_out,
  output logic       valid,
  output logic       error,
  output logic       match,
  output logic       stall
);

  typedef enum logic [1:0] {SYNC, PHASE1, PHASE2} state_t;

  // Multipliers are held in tenths so the nominal length stays integer math.
  function automatic logic [15:0] half_len(input int k);
    int m10;
    case (k)
      0:       m10 = 1;
      1:       m10 = 2;
      2:       m10 = 4;
      3:       m10 = 10;
      4:       m10 = 16;
      5:       m10 = 32;
      6:       m10 = 64;
      default: m10 = 128;
    endcase
    return 16'((HUNDREDMHZ * m10) / 20 + 1);
  endfunction

  state_t      state_reg;
  logic        s1_reg, s2_reg, s3_reg;
  logic        edge_det;
  logic [15:0] cnt_reg;
  logic [15:0] len1_reg;
  logic [7:0]  hit;
  logic        any_hit;
  logic [2:0]  hit_code;

  assign edge_det = s2_reg ^ s3_reg;

  // cnt_reg at an edge is the length of the phase that just closed (len2).
  for (genvar gi = 0; gi < 8; gi++) begin : g_setting
    localparam logic [15:0] HK = half_len(gi);
    assign hit[gi] = (len1_reg == cnt_reg) && (cnt_reg == HK) && (cnt_reg != 16'hFFFF);
  end

  assign any_hit = |hit;

  always_comb begin
    hit_code = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (hit[k]) hit_code = 3'(k);
    end
  end

  assign match = valid && (code_out == expect_in);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= SYNC;
      s1_reg    <= 1'b0;
      s2_reg    <= 1'b0;
      s3_reg    <= 1'b0;
      cnt_reg   <= 16'd0;
      len1_reg  <= 16'd0;
      code_out  <= 3'd0;
      valid     <= 1'b0;
      error     <= 1'b0;
    end else begin
      s1_reg <= clock_in;
      s2_reg <= s1_reg;
      s3_reg <= s2_reg;
      if (update) begin
        state_reg <= SYNC;
        valid     <= 1'b0;
        error     <= 1'b0;
        cnt_reg   <= 16'd0;
      end else begin
        if (edge_det) begin
          cnt_reg <= 16'd1;
        end else if (cnt_reg != 16'hFFFF) begin
          cnt_reg <= cnt_reg + 16'd1;
        end

        if (edge_det) begin
          case (state_reg)
            SYNC: state_reg <= PHASE1;
            PHASE1: begin
              len1_reg  <= cnt_reg;
              state_reg <= PHASE2;
            end
            default: begin
              state_reg <= PHASE1;
              if (any_hit) begin
                code_out <= hit_code;
                valid    <= 1'b1;
                error    <= 1'b0;
              end else begin
                valid <= 1'b0;
                error <= 1'b1;
              end
            end
          endcase
        end
`ifdef DCM_MONITOR_TIMEOUT_EN
        else if (cnt_reg == 16'(TIMEOUT)) begin
          valid     <= 1'b0;
          state_reg <= SYNC;
        end
`endif
      end
    end
  end

`ifdef DCM_MONITOR_TIMEOUT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall <= 1'b0;
    end else if (edge_det) begin
      stall <= 1'b0;
    end else if (!update && cnt_reg == 16'(TIMEOUT)) begin
      stall <= 1'b1;
    end
  end
`else
  assign stall = 1'b0;
`endif

endmodule

// File: tb/tb_dcm_monitor.sv
// Scoreboard bench for dcm_monitor: a phase-length model predicts each
// evaluation; a monitor compares when the predicted result is due.
module tb_dcm_monitor;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       clock_in = 1'b0;
  logic       update = 1'b0;
  logic [2:0] expect_in = 3'd0;
  logic [2:0] code_out;
  logic       valid, error, match, stall;

  dcm_monitor dut (
    .clock(clock), .reset(reset), .clock_in(clock_in), .update(update),
    .expect_in(expect_in), .code_out(code_out), .valid(valid),
    .error(error), .match(match), .stall(stall)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc = cyc + 1;

  typedef struct {
    int         due;
    logic       v;
    logic       e;
    logic [2:0] c;
  } exp_t;
  exp_t sbq[$];

  int checks = 0;
  int errors = 0;

  // Nominal half-periods for the default scale.
  int hval[8] = '{1, 2, 3, 6, 9, 17, 33, 65};

  // Reference model: list of phase lengths between observed transitions.
  int         mst;       // 0: waiting for first edge, 1: need len1, 2: need len2
  int         last_e;
  int         mlen1;
  logic [2:0] mcode;
  logic       mvalid, merr;
  logic       th1, th2;  // toggle history (1 and 2 steps ago)

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input int due);
    exp_t x;
    x.due = due; x.v = mvalid; x.e = merr; x.c = mcode;
    sbq.push_back(x);
  endtask

  task automatic model_reset();
    mst = 0; last_e = 0; mlen1 = 0; mcode = 3'd0;
    mvalid = 1'b0; merr = 1'b0; th1 = 1'b0; th2 = 1'b0;
    sbq.delete();
  endtask

  // e: a transition becomes visible to the detector at posedge p.
  task automatic model_tick(input logic e, input logic u, input int p);
    int  len;
    bit  found;
    if (u) begin
      mst = 0; mvalid = 1'b0; merr = 1'b0;
      push(p);
    end else if (e) begin
      len = p - last_e;
      last_e = p;
      if (mst == 0) begin
        mst = 1;
      end else if (mst == 1) begin
        mlen1 = len; mst = 2;
      end else begin
        found = 0;
        for (int k = 0; k < 8; k++) begin
          if (!found && mlen1 == hval[k] && len == hval[k]) begin
            found = 1; mcode = 3'(k);
          end
        end
        mvalid = found; merr = !found;
        push(p);
        mst = 1;
      end
    end
  endtask

  // One system cycle of stimulus; a toggle driven now is seen 3 posedges later.
  task automatic step(input logic tog, input logic upd);
    @(negedge clock);
    clock_in = clock_in ^ tog;
    update = upd;
    model_tick(th2, upd, cyc + 1);
    th2 = th1;
    th1 = tog;
  endtask

  task automatic seg(input int hi, input int lo, input int ntog, input logic upd_first);
    if (upd_first) step(1'b0, 1'b1);
    for (int i = 0; i < ntog; i++) begin
      step(1'b1, 1'b0);
      repeat (((i % 2) == 0 ? hi : lo) - 1) step(1'b0, 1'b0);
    end
    repeat (3) step(1'b0, 1'b0);
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_code"}, code_out, mcode);
    chk({tag, "_valid"}, valid, mvalid);
    chk({tag, "_error"}, error, merr);
  endtask

  // Monitor: compares the DUT against each prediction on its due cycle.
  exp_t mon_x;
  initial begin
    forever begin
      @(posedge clock);
      #1;
      while (sbq.size() > 0 && sbq[0].due < cyc) begin
        mon_x = sbq.pop_front();
        chk("sb_missed", cyc, mon_x.due);
      end
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
        mon_x = sbq.pop_front();
        chk("sb_valid", valid, mon_x.v);
        chk("sb_error", error, mon_x.e);
        chk("sb_code", code_out, mon_x.c);
        chk("sb_match", match, mon_x.v && (mon_x.c == expect_in));
        chk("sb_stall", stall, 0);
        $display("eval @%0d: code=%0d valid=%0b error=%0b match=%0b", cyc, code_out, valid, error, match);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k, hi, lo, ntog;
    logic upd;
    model_reset();
    #1;
    chk("rst_code", code_out, 0);
    chk("rst_valid", valid, 0);
    chk("rst_error", error, 0);
    chk("rst_match", match, 0);
    chk("rst_stall", stall, 0);
    repeat (3) @(negedge clock);
    reset = 1'b1;

    // 6-cycle half periods decode to code 3
    expect_in = 3'd3;
    seg(6, 6, 8, 1'b0);
    chk("h6_code", code_out, 3);
    chk("h6_valid", valid, 1);
    chk("h6_match", match, 1);

    // Rate change to toggle-every-cycle without update
    expect_in = 3'd0;
    seg(1, 1, 10, 1'b0);
    chk("h1_code", code_out, 0);
    chk("h1_valid", valid, 1);

    // Slowest setting after an update
    expect_in = 3'd7;
    seg(65, 65, 5, 1'b1);
    chk("h65_code", code_out, 7);
    chk("h65_match", match, 1);

    // Asymmetric waveform never matches; code holds
    seg(9, 17, 6, 1'b0);
    chk("asym_error", error, 1);
    chk("asym_valid", valid, 0);
    chk("asym_code", code_out, 7);

    // Update coincident with the closing transition of a period
    step(1'b0, 1'b1);
    step(1'b1, 1'b0); repeat (3) step(1'b0, 1'b0);
    step(1'b1, 1'b0); repeat (3) step(1'b0, 1'b0);
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0);
    chk("updclose_valid", valid, 0);
    chk("updclose_error", error, 0);
    expect_in = 3'd1;
    seg(2, 2, 4, 1'b0);
    chk("after_upd_code", code_out, 1);
    chk("after_upd_valid", valid, 1);

    // Reset mid-measurement
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b0);
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("mrst_code", code_out, 0);
    chk("mrst_valid", valid, 0);
    chk("mrst_error", error, 0);
    chk("mrst_match", match, 0);
    model_reset();
    clock_in = 1'b0;
    repeat (4) step(1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    seg(3, 3, 5, 1'b0);
    chk("post_rst_code", code_out, 2);

    // Randomized segments against the model
    for (int it = 0; it < 25; it++) begin
      k = $urandom_range(0, 7);
      upd = ($urandom_range(0, 2) == 0);
      hi = hval[k];
      lo = ($urandom_range(0, 4) == 0) ? hval[(k + 1) % 8] : hi;
      ntog = $urandom_range(3, 7);
      expect_in = ($urandom_range(0, 1) == 1) ? 3'(k) : 3'($urandom_range(0, 7));
      seg(hi, lo, ntog, upd);
      chk_model("rand");
      expect_in = 3'($urandom_range(0, 7));
      #1;
      chk("rand_match_comb", match, mvalid && (mcode == expect_in));
    end

`ifdef DCM_MONITOR_TIMEOUT_EN
    step(1'b0, 1'b1);
    repeat (200) step(1'b0, 1'b0);
    chk("pre_stall", stall, 0);
    repeat (100) step(1'b0, 1'b0);
    chk("stall_set", stall, 1);
    chk("stall_valid", valid, 0);
    expect_in = 3'd1;
    seg(2, 2, 5, 1'b0);
    chk("stall_clear", stall, 0);
    chk("stall_code", code_out, 1);
    chk("stall_recover_valid", valid, 1);
`else
    step(1'b0, 1'b0);
    chk("stall_tied", stall, 0);
`endif

    for (int w = 0; w < 100 && sbq.size() > 0; w++) @(posedge clock);
    #2;
    chk("sb_drained", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
